// File: rtl/wb_grf_if.sv
// wb_grf_if: the write-back bundle between the MEM/WB pipeline register,
// the register file, and the decode-stage read ports.
//   slave  : the register file (consumes write-back fields, drives read data
//            and the committed-write observation signals)
//   master : the producer side (pipeline register, decode stage, bench)
interface wb_grf_if;
  logic [1:0]  Mem2Reg;
  logic        RegWrite;
  logic [2:0]  ld_op;
  logic [31:0] dm_data;
  logic [4:0]  A3;
  logic [31:0] ALU_C;
  logic [31:0] pc_add4;
  logic        cond_link;
  logic        cmp_check;
  logic [31:0] CP0_Dout;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] wb_pc;
  logic [31:0] wr_count;

  modport slave (
    input  Mem2Reg, RegWrite, ld_op, dm_data, A3, ALU_C, pc_add4,
           cond_link, cmp_check, CP0_Dout, rs_addr, rt_addr,
    output rs_data, rt_data, wb_en, wb_addr, wb_data, wb_pc, wr_count
  );

  modport master (
    output Mem2Reg, RegWrite, ld_op, dm_data, A3, ALU_C, pc_add4,
           cond_link, cmp_check, CP0_Dout, rs_addr, rt_addr,
    input  rs_data, rt_data, wb_en, wb_addr, wb_data, wb_pc, wr_count
  );
endinterface

// File: rtl/wb_grf.sv
// wb_grf: write-back stage plus 32x32 general register file.
// Extends load data, selects the write-back value, commits it to the GRF
// and serves two combinational read ports with same-cycle write-through.
// Ports:
//   clk    : clock, all state updates on the rising edge
//   reset  : synchronous active-high; clears GRF and commit counter
//   bus    : wb_grf_if.slave (write-back fields in, read data and
//            committed-write observation out)
module wb_grf #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic      clk,
  input  logic      reset,
  wb_grf_if.slave   bus
);

  localparam logic [2:0] LD_LB  = 3'd1;
  localparam logic [2:0] LD_LBU = 3'd2;
  localparam logic [2:0] LD_LH  = 3'd3;
  localparam logic [2:0] LD_LHU = 3'd4;

  logic [31:0] r_grf [0:31];
  logic [31:0] r_wr_count;

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ld_ext;
  logic [31:0] w_wb_data;
  logic        w_wb_en;

  // Byte/half lane selection from the low address bits.
  always_comb begin
    w_byte = bus.dm_data[7:0];
    case (bus.ALU_C[1:0])
      2'd0: w_byte = bus.dm_data[7:0];
      2'd1: w_byte = bus.dm_data[15:8];
      2'd2: w_byte = bus.dm_data[23:16];
      2'd3: w_byte = bus.dm_data[31:24];
      default: w_byte = bus.dm_data[7:0];
    endcase
    w_half = bus.ALU_C[1] ? bus.dm_data[31:16] : bus.dm_data[15:0];
  end

  // Unlisted load codes fall back to a full word.
  always_comb begin
    w_ld_ext = bus.dm_data;
    case (bus.ld_op)
      LD_LB:   w_ld_ext = {{24{w_byte[7]}}, w_byte};
      LD_LBU:  w_ld_ext = {24'd0, w_byte};
      LD_LH:   w_ld_ext = {{16{w_half[15]}}, w_half};
      LD_LHU:  w_ld_ext = {16'd0, w_half};
      default: w_ld_ext = bus.dm_data;
    endcase
  end

  always_comb begin
    w_wb_data = bus.ALU_C;
    case (bus.Mem2Reg)
      2'd0: w_wb_data = bus.ALU_C;
      2'd1: w_wb_data = w_ld_ext;
      2'd2: w_wb_data = bus.pc_add4 + 32'd4;
      2'd3: w_wb_data = bus.CP0_Dout;
      default: w_wb_data = bus.ALU_C;
    endcase
  end

  // A conditional link only commits when the carried branch compare held.
  // An all-zero bubble has RegWrite=0 and A3=0, so it never commits.
  assign w_wb_en = bus.RegWrite & (bus.A3 != 5'd0) & (~bus.cond_link | bus.cmp_check);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) r_grf[i] <= 32'd0;
      r_wr_count <= 32'd0;
    end else if (w_wb_en) begin
      r_grf[bus.A3] <= w_wb_data;
      r_wr_count    <= r_wr_count + 32'd1;
    end
  end

  // Write-through bypass lets decode consume a WB result without a stall.
  assign bus.rs_data = (bus.rs_addr == 5'd0)                ? 32'd0 :
                       (w_wb_en && bus.rs_addr == bus.A3)   ? w_wb_data :
                                                              r_grf[bus.rs_addr];
  assign bus.rt_data = (bus.rt_addr == 5'd0)                ? 32'd0 :
                       (w_wb_en && bus.rt_addr == bus.A3)   ? w_wb_data :
                                                              r_grf[bus.rt_addr];

  assign bus.wb_en    = w_wb_en;
  assign bus.wb_addr  = w_wb_en ? bus.A3 : 5'd0;
  assign bus.wb_data  = w_wb_data;
  // The reset-PC term only names the boot instruction; both arms equal pc_add4-4.
  assign bus.wb_pc    = (bus.pc_add4 == RESET_PC + 32'd4) ? RESET_PC : bus.pc_add4 - 32'd4;
  assign bus.wr_count = r_wr_count;

endmodule

// File: tb/tb_wb_grf.sv
module tb_wb_grf;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wb_grf_if bus();

  wb_grf #(.RESET_PC(32'h0000_3000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit          chk;
    string       name;
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] pc;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_grf [32];
  logic [31:0] m_cnt;

  function automatic logic [31:0] ref_ext(input logic [2:0] op, input logic [31:0] dm,
                                          input logic [31:0] a);
    logic [31:0] b, h;
    b = (dm >> (8 * (a % 4))) & 32'hFF;
    h = (dm >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    case (op)
      3'd1: return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
      3'd2: return b;
      3'd3: return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      3'd4: return h;
      default: return dm;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: one expectation per stimulus cycle, checked mid-low-phase.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        if (e.chk) begin
          chk({e.name, ".wb_en"},    {31'd0, bus.wb_en}, {31'd0, e.en});
          chk({e.name, ".wb_addr"},  {27'd0, bus.wb_addr}, {27'd0, e.addr});
          chk({e.name, ".wb_data"},  bus.wb_data,  e.data);
          chk({e.name, ".rs_data"},  bus.rs_data,  e.rs);
          chk({e.name, ".rt_data"},  bus.rt_data,  e.rt);
          chk({e.name, ".wb_pc"},    bus.wb_pc,    e.pc);
          chk({e.name, ".wr_count"}, bus.wr_count, e.cnt);
        end
      end
    end
  end

  task automatic apply(input string nm, input bit do_chk, input logic rst,
                       input logic [1:0] m2r, input logic rw, input logic [2:0] op,
                       input logic [31:0] dm, input logic [4:0] a3, input logic [31:0] aluc,
                       input logic [31:0] pc4, input logic cl, input logic cc,
                       input logic [31:0] cp0, input logic [4:0] rsa, input logic [4:0] rta);
    exp_t e;
    @(negedge clk);
    reset = rst;
    bus.Mem2Reg = m2r; bus.RegWrite = rw; bus.ld_op = op; bus.dm_data = dm;
    bus.A3 = a3; bus.ALU_C = aluc; bus.pc_add4 = pc4; bus.cond_link = cl;
    bus.cmp_check = cc; bus.CP0_Dout = cp0; bus.rs_addr = rsa; bus.rt_addr = rta;
    e.chk  = do_chk;
    e.name = nm;
    case (m2r)
      2'd0: e.data = aluc;
      2'd1: e.data = ref_ext(op, dm, aluc);
      2'd2: e.data = pc4 + 32'd4;
      default: e.data = cp0;
    endcase
    e.en   = rw && (a3 != 0) && (!cl || cc);
    e.addr = e.en ? a3 : 5'd0;
    e.rs   = (rsa == 0) ? 32'd0 : (e.en && rsa == a3) ? e.data : m_grf[rsa];
    e.rt   = (rta == 0) ? 32'd0 : (e.en && rta == a3) ? e.data : m_grf[rta];
    e.pc   = pc4 - 32'd4;
    e.cnt  = m_cnt;
    q.push_back(e);
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) m_grf[i] = 32'd0;
      m_cnt = 32'd0;
    end else if (e.en) begin
      m_grf[a3] = e.data;
      m_cnt = m_cnt + 32'd1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    bus.Mem2Reg = '0; bus.RegWrite = 1'b0; bus.ld_op = '0; bus.dm_data = '0;
    bus.A3 = '0; bus.ALU_C = '0; bus.pc_add4 = '0; bus.cond_link = 1'b0;
    bus.cmp_check = 1'b0; bus.CP0_Dout = '0; bus.rs_addr = '0; bus.rt_addr = '0;
    for (int i = 0; i < 32; i++) m_grf[i] = 32'd0;
    m_cnt = 32'd0;

    // Pre-reset state is unknown, so the reset cycle itself is not checked.
    apply("reset",     0, 1, 2'd0, 0, 3'd0, 32'h0, 5'd0, 32'h0, 32'h3004, 0, 0, 32'h0, 5'd0, 5'd0);
    apply("post_rst",  1, 0, 2'd0, 0, 3'd0, 32'h0, 5'd0, 32'h0, 32'h3004, 0, 0, 32'h0, 5'd5, 5'd31);

    apply("lb3",   1, 0, 2'd1, 1, 3'd1, 32'h80FF7F01, 5'd8, 32'h0000_1003, 32'h3008, 0, 0, 32'h0, 5'd8, 5'd0);
    apply("lbu3",  1, 0, 2'd1, 1, 3'd2, 32'h80FF7F01, 5'd8, 32'h0000_1003, 32'h300C, 0, 0, 32'h0, 5'd0, 5'd8);
    apply("lh2",   1, 0, 2'd1, 1, 3'd3, 32'h80FF7F01, 5'd8, 32'h0000_1002, 32'h3010, 0, 0, 32'h0, 5'd8, 5'd8);
    apply("lhu0",  1, 0, 2'd1, 1, 3'd4, 32'h80FF7F01, 5'd8, 32'h0000_1000, 32'h3014, 0, 0, 32'h0, 5'd1, 5'd2);
    apply("ld6",   1, 0, 2'd1, 1, 3'd6, 32'h80FF7F01, 5'd8, 32'h0000_1001, 32'h3018, 0, 0, 32'h0, 5'd0, 5'd0);
    apply("rd8",   1, 0, 2'd0, 0, 3'd0, 32'h0, 5'd8, 32'h0, 32'h301C, 0, 0, 32'h0, 5'd8, 5'd8);

    apply("byp9",  1, 0, 2'd0, 1, 3'd0, 32'h0, 5'd9, 32'h12345678, 32'h3020, 0, 0, 32'h0, 5'd9, 5'd8);
    apply("zero",  1, 0, 2'd0, 1, 3'd0, 32'h0, 5'd0, 32'hDEADBEEF, 32'h3024, 0, 0, 32'h0, 5'd0, 5'd9);

    apply("link",  1, 0, 2'd2, 1, 3'd0, 32'h0, 5'd31, 32'h0, 32'h3010, 0, 0, 32'h0, 5'd0, 5'd0);
    apply("rd31",  1, 0, 2'd0, 0, 3'd0, 32'h0, 5'd0, 32'h0, 32'h3004, 0, 0, 32'h0, 5'd31, 5'd31);
    apply("cl_n",  1, 0, 2'd2, 1, 3'd0, 32'h0, 5'd10, 32'h0, 32'h3040, 1, 0, 32'h0, 5'd10, 5'd31);
    apply("cl_y",  1, 0, 2'd2, 1, 3'd0, 32'h0, 5'd10, 32'h0, 32'h3040, 1, 1, 32'h0, 5'd10, 5'd9);
    apply("cp0",   1, 0, 2'd3, 1, 3'd0, 32'h0, 5'd11, 32'h0, 32'h3048, 0, 0, 32'hCAFE0001, 5'd10, 5'd11);

    apply("rst_wr", 1, 1, 2'd0, 1, 3'd0, 32'h0, 5'd4, 32'h55, 32'h304C, 0, 0, 32'h0, 5'd4, 5'd8);
    apply("rd4",    1, 0, 2'd0, 0, 3'd0, 32'h0, 5'd0, 32'h0, 32'h3050, 0, 0, 32'h0, 5'd4, 5'd31);

    // Counter wrap: preload the counter, then one commit.
    @(negedge clk);
    force dut.r_wr_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_wr_count;
    m_cnt = 32'hFFFF_FFFF;
    apply("wrap_pre",  1, 0, 2'd0, 1, 3'd0, 32'h0, 5'd12, 32'h77, 32'h3054, 0, 0, 32'h0, 5'd12, 5'd0);
    apply("wrap_post", 1, 0, 2'd0, 0, 3'd0, 32'h0, 5'd0, 32'h0, 32'h3058, 0, 0, 32'h0, 5'd12, 5'd12);

    for (int n = 0; n < 500; n++) begin
      logic rr;
      logic [4:0] a3, rsa, rta;
      rr  = ($urandom_range(0, 39) == 0);
      a3  = 5'($urandom_range(0, 7));
      rsa = ($urandom_range(0, 3) == 0) ? a3 : 5'($urandom_range(0, 31));
      rta = ($urandom_range(0, 3) == 0) ? rsa : 5'($urandom_range(0, 31));
      if ($urandom_range(0, 9) == 0)
        apply("bubble", 1, rr, 2'd0, 0, 3'd0, 32'h0, 5'd0, 32'h0, 32'h0, 0, 0, 32'h0, rsa, rta);
      else
        apply("rand", 1, rr, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              3'($urandom_range(0, 7)), $urandom, a3, $urandom, $urandom,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, rsa, rta);
    end

    repeat (3) @(negedge clk);
    #3;
    chk("queue_drained", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
